// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready, flush and bubble.
// Ports: clk, rst, flush, bubble, in_*, out_*, occupancy (entries held).
module pipe_stage_skid #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned SKID            = 0,
  parameter int unsigned ZERO_ON_INVALID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam bit ZOI = (ZERO_ON_INVALID != 0);

  logic acc;
  logic take;

  assign acc  = in_valid & in_ready;
  assign take = out_valid & out_ready;

  if (SKID == 0) begin : g_single

    logic              m_v;
    logic [DATA_W-1:0] m_data;

    // Ready looks through to out_ready so a full
    // register can refill in the cycle it drains.
    assign in_ready = ~flush & ~bubble
                    & (~m_v | out_ready);

    always_ff @(posedge clk) begin
      if (rst) begin
        m_v    <= 1'b0;
        m_data <= '0;
      end else if (flush) begin
        m_v <= 1'b0;
        if (ZOI) m_data <= '0;
      end else begin
        m_v <= acc | (m_v & ~out_ready);
        if (acc) begin
          m_data <= in_data;
        end else if (ZOI && take) begin
          m_data <= '0;
        end
      end
    end

    assign out_valid = m_v;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_v};

  end else begin : g_skid

    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
    } state_t;

    state_t            st_q;
    state_t            st_d;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] m_d;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] s_d;
    logic              m_v;
    logic              s_v;

    assign m_v = (st_q != EMPTY);
    assign s_v = (st_q == FULL);

    // Registered-only ready: the skid entry
    // absorbs the word that arrives while
    // downstream stalls.
    assign in_ready = ~s_v & ~flush & ~bubble;

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q <= EMPTY;
        m_q  <= '0;
        s_q  <= '0;
      end else begin
        st_q <= st_d;
        m_q  <= m_d;
        s_q  <= s_d;
      end
    end

    always_comb begin
      st_d = st_q;
      m_d  = m_q;
      s_d  = s_q;
      if (flush) begin
        st_d = EMPTY;
        if (ZOI) begin
          m_d = '0;
          s_d = '0;
        end
      end else begin
        case (st_q)
          EMPTY: begin
            if (acc) begin
              st_d = ONE;
              m_d  = in_data;
            end
          end
          ONE: begin
            if (acc && take) begin
              m_d = in_data;
            end else if (acc) begin
              st_d = FULL;
              s_d  = in_data;
            end else if (take) begin
              st_d = EMPTY;
              if (ZOI) m_d = '0;
            end
          end
          FULL: begin
            if (take) begin
              st_d = ONE;
              m_d  = s_q;
              if (ZOI) s_d = '0;
            end
          end
          default: begin
            st_d = EMPTY;
          end
        endcase
      end
    end

    assign out_valid = m_v;
    assign out_data  = m_q;
    assign occupancy = {1'b0, m_v}
                     + {1'b0, s_v};

  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (SKID=0, SKID=1,
// SKID=1 with stale data) driven from one shared stimulus.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic       bubble;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic [2:0]      ir;
  logic [2:0]      ov;
  logic [2:0][7:0] od;
  logic [2:0][1:0] oc;

  pipe_stage_skid #(
    .DATA_W(8), .SKID(0), .ZERO_ON_INVALID(1)
  ) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .bubble(bubble), .in_valid(in_valid),
    .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .occupancy(oc[0])
  );

  pipe_stage_skid #(
    .DATA_W(8), .SKID(1), .ZERO_ON_INVALID(1)
  ) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .bubble(bubble), .in_valid(in_valid),
    .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .occupancy(oc[1])
  );

  pipe_stage_skid #(
    .DATA_W(8), .SKID(1), .ZERO_ON_INVALID(0)
  ) u2 (
    .clk(clk), .rst(rst), .flush(flush),
    .bubble(bubble), .in_valid(in_valid),
    .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .occupancy(oc[2])
  );

  typedef struct {
    int       dut;
    bit       chk;
    bit       rst;
    bit       fl;
    bit       bb;
    bit       iv;
    bit [7:0] id;
    bit       ordy;
    bit       e_ir;
    bit       e_ov;
    bit [7:0] e_od;
    bit [1:0] e_oc;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic v(
    input int d, input bit c, input bit r,
    input bit f, input bit b, input bit i,
    input bit [7:0] dt, input bit o,
    input bit eir, input bit eov,
    input bit [7:0] eod, input bit [1:0] eoc
  );
    vec_t x;
    x.dut = d;   x.chk = c;   x.rst = r;
    x.fl = f;    x.bb = b;    x.iv = i;
    x.id = dt;   x.ordy = o;  x.e_ir = eir;
    x.e_ov = eov; x.e_od = eod; x.e_oc = eoc;
    vq.push_back(x);
  endtask

  task automatic cmp(
    input string nm, input int idx,
    input int act, input int exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s #%0d got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(
    input bit r, input bit f, input bit b,
    input bit i, input bit [7:0] dt, input bit o
  );
    @(negedge clk);
    rst = r; flush = f; bubble = b;
    in_valid = i; in_data = dt; out_ready = o;
    #1;
  endtask

  task automatic check_all(
    input int d, input int idx, input bit eir,
    input bit eov, input bit [7:0] eod,
    input bit [1:0] eoc
  );
    cmp("in_ready", idx, int'(ir[d]), int'(eir));
    cmp("out_valid", idx, int'(ov[d]), int'(eov));
    cmp("out_data", idx, int'(od[d]), int'(eod));
    cmp("occupancy", idx, int'(oc[d]), int'(eoc));
  endtask

  bit [7:0] q[$];
  bit       e_ir;
  bit       r_iv;
  bit       r_or;
  bit [7:0] r_id;

  initial begin
    rst = 1'b1; flush = 1'b0; bubble = 1'b0;
    in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0;

    // reset held two cycles, then released
    v(1,0,1,0,0,0,8'h00,0, 0,0,8'h00,0);
    v(1,1,1,0,0,0,8'h00,0, 1,0,8'h00,0);
    v(1,1,0,0,0,0,8'h00,0, 1,0,8'h00,0);
    // skid fills, holds, drains in order
    v(1,1,0,0,0,1,8'h0A,0, 1,0,8'h00,0);
    v(1,1,0,0,0,1,8'h0B,0, 1,1,8'h0A,1);
    v(1,1,0,0,0,1,8'h0C,0, 0,1,8'h0A,2);
    v(1,1,0,0,0,0,8'h00,1, 0,1,8'h0A,2);
    v(1,1,0,0,0,0,8'h00,1, 1,1,8'h0B,1);
    v(1,1,0,0,0,0,8'h00,0, 1,0,8'h00,0);
    // flush while FULL drops everything
    v(1,1,0,0,0,1,8'h0A,0, 1,0,8'h00,0);
    v(1,1,0,0,0,1,8'h0B,0, 1,1,8'h0A,1);
    v(1,1,0,1,0,1,8'h0C,0, 0,1,8'h0A,2);
    v(1,1,0,0,0,0,8'h00,0, 1,0,8'h00,0);
    v(1,1,0,0,0,0,8'h00,1, 1,0,8'h00,0);
    // bubble drains FULL without accepting
    v(1,1,0,0,0,1,8'h0D,0, 1,0,8'h00,0);
    v(1,1,0,0,0,1,8'h0E,0, 1,1,8'h0D,1);
    v(1,1,0,0,1,1,8'h0F,1, 0,1,8'h0D,2);
    v(1,1,0,0,1,1,8'h0F,1, 0,1,8'h0E,1);
    v(1,1,0,0,1,1,8'h0F,1, 0,0,8'h00,0);
    v(1,1,0,0,0,1,8'h0F,1, 1,0,8'h00,0);
    v(1,1,0,0,0,0,8'h00,1, 1,1,8'h0F,1);
    v(1,1,0,0,0,0,8'h00,1, 1,0,8'h00,0);

    // single entry: bubble inserts a NOP
    v(0,0,1,0,0,0,8'h00,0, 0,0,8'h00,0);
    v(0,1,0,0,0,0,8'h00,0, 1,0,8'h00,0);
    v(0,1,0,0,1,0,8'h00,0, 0,0,8'h00,0);
    v(0,1,0,0,0,1,8'h05,1, 1,0,8'h00,0);
    v(0,1,0,0,1,1,8'h06,1, 0,1,8'h05,1);
    v(0,1,0,0,1,1,8'h06,1, 0,0,8'h00,0);
    v(0,1,0,0,0,1,8'h06,1, 1,0,8'h00,0);
    // back-to-back, hold, ready passthrough
    v(0,1,0,0,0,1,8'h07,1, 1,1,8'h06,1);
    v(0,1,0,0,0,1,8'h08,0, 0,1,8'h07,1);
    v(0,1,0,0,0,1,8'h08,0, 0,1,8'h07,1);
    v(0,1,0,0,0,1,8'h08,1, 1,1,8'h07,1);
    v(0,1,0,0,0,0,8'h00,0, 0,1,8'h08,1);
    v(0,1,0,1,0,1,8'h09,0, 0,1,8'h08,1);
    v(0,1,0,0,0,0,8'h00,0, 1,0,8'h00,0);
    // reset mid-transfer
    v(0,1,0,0,0,1,8'h03,0, 1,0,8'h00,0);
    v(0,1,1,0,0,1,8'h04,0, 0,1,8'h03,1);
    v(0,1,0,0,0,0,8'h00,0, 1,0,8'h00,0);

    // stale data kept when not zeroing
    v(2,0,1,0,0,0,8'h00,0, 0,0,8'h00,0);
    v(2,1,0,0,0,0,8'h00,0, 1,0,8'h00,0);
    v(2,1,0,0,0,1,8'h0A,0, 1,0,8'h00,0);
    v(2,1,0,0,0,0,8'h00,1, 1,1,8'h0A,1);
    v(2,1,0,0,0,0,8'h00,0, 1,0,8'h0A,0);
    v(2,1,0,0,0,1,8'h0B,0, 1,0,8'h0A,0);
    v(2,1,0,1,0,0,8'h00,0, 0,1,8'h0B,1);
    v(2,1,0,0,0,0,8'h00,0, 1,0,8'h0B,0);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].fl, vq[k].bb,
            vq[k].iv, vq[k].id, vq[k].ordy);
      if (vq[k].chk)
        check_all(vq[k].dut, k, vq[k].e_ir,
                  vq[k].e_ov, vq[k].e_od,
                  vq[k].e_oc);
    end

    // skid streaming 1..8, no gaps
    drive(1,0,0,0,8'h00,1);
    for (int k = 1; k <= 9; k++) begin
      drive(0, 0, 0, k <= 8, 8'(k), 1);
      check_all(1, 100 + k, 1'b1, k >= 2,
                (k >= 2) ? 8'(k - 1) : 8'h00,
                (k >= 2) ? 2'd1 : 2'd0);
    end

    // random traffic against a FIFO model
    drive(1,0,0,0,8'h00,0);
    q.delete();
    for (int k = 0; k < 80; k++) begin
      r_iv = 1'($urandom_range(0, 1));
      r_or = ($urandom_range(0, 2) != 0);
      r_id = 8'($urandom_range(1, 255));
      drive(0, 0, 0, r_iv, r_id, r_or);
      e_ir = (q.size() < 2);
      check_all(1, 200 + k, e_ir,
                q.size() > 0,
                (q.size() > 0) ? q[0] : 8'h00,
                2'(q.size()));
      if (r_or && q.size() > 0)
        void'(q.pop_front());
      if (r_iv && e_ir)
        q.push_back(r_id);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
